// File: rtl/if_stage_pkg.sv
// Shared encodings for the fetch stage: PC-source selects (also used by
// hazard detection), the canonical NOP word and the IF FSM state codes.
package if_stage_pkg;

    // PC source select driven by hazard detection
    localparam logic [2:0] PC_SEL_HOLD   = 3'b000;
    localparam logic [2:0] PC_SEL_SEQ    = 3'b001;
    localparam logic [2:0] PC_SEL_BRANCH = 3'b010;
    localparam logic [2:0] PC_SEL_JALR   = 3'b011;
    localparam logic [2:0] PC_SEL_TRAP   = 3'b100;

    // addi x0, x0, 0
    localparam logic [31:0] INSN_NOP = 32'h0000_0013;

    // IF state encodings
    localparam logic [1:0] S_RESET = 2'd0;
    localparam logic [1:0] S_REQ   = 2'd1;
    localparam logic [1:0] S_HOLD  = 2'd2;
    localparam logic [1:0] S_DROP  = 2'd3;

    // A redirect is any select that loads a new target into the PC
    function automatic logic is_redirect(input logic [2:0] sel);
        return (sel == PC_SEL_BRANCH) || (sel == PC_SEL_JALR) || (sel == PC_SEL_TRAP);
    endfunction

endpackage

// File: rtl/if_hold_buf.sv
// One-entry {pc, instr} buffer with load, clear and a valid flag.
// Clear wins over load when both are asserted.
module if_hold_buf #(
    parameter int XLEN = 32
) (
    input  logic            clk,
    input  logic            rst_n,
    input  logic            i_load,
    input  logic            i_clear,
    input  logic [XLEN-1:0] i_pc,
    input  logic [31:0]     i_instr,
    output logic            o_valid,
    output logic [XLEN-1:0] o_pc,
    output logic [31:0]     o_instr
);

    logic            r_valid;
    logic [XLEN-1:0] r_pc;
    logic [31:0]     r_instr;

    // Capture a response on load, invalidate on clear
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_valid <= 1'b0;
            r_pc    <= '0;
            r_instr <= '0;
        end else if (i_clear) begin
            r_valid <= 1'b0;
        end else if (i_load) begin
            r_valid <= 1'b1;
            r_pc    <= i_pc;
            r_instr <= i_instr;
        end
    end

    assign o_valid = r_valid;
    assign o_pc    = r_pc;
    assign o_instr = r_instr;

endmodule

// File: rtl/if_stage.sv
// Instruction-fetch stage with IF/ID pipeline register. Owns the PC, keeps a
// single request outstanding to instruction memory, parks a response that
// arrives during a stall and discards responses made stale by a redirect.
module if_stage
    import if_stage_pkg::*;
#(
    parameter int          XLEN     = 32,
    parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
    input  logic            clk,
    input  logic            rst_n,
    input  logic [2:0]      pc_sel,
    input  logic            IFID_write,
    input  logic            kill_IF,
    input  logic [XLEN-1:0] branch_target,
    input  logic [XLEN-1:0] jalr_target,
    input  logic [XLEN-1:0] trap_vec,
    output logic            imem_req,
    output logic [XLEN-1:0] imem_addr,
    input  logic            imem_ack,
    input  logic [31:0]     imem_rdata,
    output logic [XLEN-1:0] ifid_pc,
    output logic [31:0]     ifid_instr,
    output logic            ifid_valid
);

    logic [1:0]      r_state;
    logic [XLEN-1:0] r_pc;
    logic [XLEN-1:0] r_ifid_pc;
    logic [31:0]     r_ifid_instr;
    logic            r_ifid_valid;

    logic [1:0]      w_state_nxt;
    logic [XLEN-1:0] w_pc_nxt;
    logic [XLEN-1:0] w_target;
    logic [XLEN-1:0] w_pc_adv;
    logic            w_redirect;
    logic            w_ifid_ld;
    logic [XLEN-1:0] w_ifid_pc_nxt;
    logic [31:0]     w_ifid_instr_nxt;
    logic            w_ifid_valid_nxt;
    logic            w_buf_load;
    logic            w_buf_clear;
    logic            w_buf_valid;
    logic [XLEN-1:0] w_buf_pc;
    logic [31:0]     w_buf_instr;

    if_hold_buf #(
        .XLEN(XLEN)
    ) u_hold_buf (
        .clk     (clk),
        .rst_n   (rst_n),
        .i_load  (w_buf_load),
        .i_clear (w_buf_clear),
        .i_pc    (r_pc),
        .i_instr (imem_rdata),
        .o_valid (w_buf_valid),
        .o_pc    (w_buf_pc),
        .o_instr (w_buf_instr)
    );

    // Next-state, next-PC and IF/ID load decisions; redirect > stall > normal
    always_comb begin
        w_redirect = is_redirect(pc_sel);
        case (pc_sel)
            PC_SEL_BRANCH: w_target = branch_target;
            PC_SEL_JALR:   w_target = jalr_target;
            default:       w_target = trap_vec;
        endcase
        w_pc_adv = (pc_sel == PC_SEL_HOLD) ? r_pc : r_pc + XLEN'(4);

        w_state_nxt      = r_state;
        w_pc_nxt         = r_pc;
        w_ifid_ld        = 1'b0;
        w_ifid_pc_nxt    = r_ifid_pc;
        w_ifid_instr_nxt = r_ifid_instr;
        w_ifid_valid_nxt = r_ifid_valid;
        w_buf_load       = 1'b0;
        w_buf_clear      = 1'b0;

        if (w_redirect) begin
            w_pc_nxt         = w_target;
            w_ifid_ld        = 1'b1;
            w_ifid_instr_nxt = INSN_NOP;
            w_ifid_valid_nxt = 1'b0;
            w_buf_clear      = 1'b1;
            // A repeat redirect while already dropping keeps waiting for the
            // same stale ack so only one request is ever in flight.
            if ((r_state == S_REQ || r_state == S_DROP) && !imem_ack)
                w_state_nxt = S_DROP;
            else
                w_state_nxt = S_REQ;
        end else begin
            case (r_state)
                S_RESET: w_state_nxt = S_REQ;
                S_REQ: begin
                    if (imem_ack) begin
                        if (IFID_write) begin
                            w_ifid_ld        = 1'b1;
                            w_ifid_pc_nxt    = r_pc;
                            w_ifid_instr_nxt = kill_IF ? INSN_NOP : imem_rdata;
                            w_ifid_valid_nxt = !kill_IF;
                            w_pc_nxt         = w_pc_adv;
                        end else begin
                            w_buf_load  = 1'b1;
                            w_state_nxt = S_HOLD;
                        end
                    end
                end
                S_HOLD: begin
                    if (IFID_write && w_buf_valid) begin
                        w_ifid_ld        = 1'b1;
                        w_ifid_pc_nxt    = w_buf_pc;
                        w_ifid_instr_nxt = kill_IF ? INSN_NOP : w_buf_instr;
                        w_ifid_valid_nxt = !kill_IF;
                        w_pc_nxt         = w_pc_adv;
                        w_buf_clear      = 1'b1;
                        w_state_nxt      = S_REQ;
                    end
                end
                default: begin
                    if (imem_ack)
                        w_state_nxt = S_REQ;
                end
            endcase
        end
    end

    // State, PC and IF/ID register update
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state      <= S_RESET;
            r_pc         <= XLEN'(RESET_PC);
            r_ifid_pc    <= '0;
            r_ifid_instr <= INSN_NOP;
            r_ifid_valid <= 1'b0;
        end else begin
            r_state <= w_state_nxt;
            r_pc    <= w_pc_nxt;
            if (w_ifid_ld) begin
                r_ifid_pc    <= w_ifid_pc_nxt;
                r_ifid_instr <= w_ifid_instr_nxt;
                r_ifid_valid <= w_ifid_valid_nxt;
            end
        end
    end

    assign imem_req   = (r_state == S_REQ);
    assign imem_addr  = r_pc;
    assign ifid_pc    = r_ifid_pc;
    assign ifid_instr = r_ifid_instr;
    assign ifid_valid = r_ifid_valid;

endmodule

// File: tb/tb_if_stage.sv
// Directed bench for if_stage: the instruction memory is driven by hand,
// one clock at a time, so each ack lands on an exactly chosen edge.
module tb_if_stage;

    logic        clk = 1'b0;
    logic        rst_n;
    logic [2:0]  pc_sel;
    logic        IFID_write;
    logic        kill_IF;
    logic [31:0] branch_target;
    logic [31:0] jalr_target;
    logic [31:0] trap_vec;
    logic        imem_req;
    logic [31:0] imem_addr;
    logic        imem_ack;
    logic [31:0] imem_rdata;
    logic [31:0] ifid_pc;
    logic [31:0] ifid_instr;
    logic        ifid_valid;

    int n_vec = 0;
    int n_err = 0;

    localparam logic [31:0] NOP = 32'h0000_0013;
    localparam logic [31:0] WA  = 32'h0010_0093;
    localparam logic [31:0] WB  = 32'h0020_0113;
    localparam logic [31:0] WC  = 32'h0030_0193;
    localparam logic [31:0] WD  = 32'h0040_0213;
    localparam logic [31:0] WE  = 32'h0050_0293;
    localparam logic [31:0] WF  = 32'h0060_0313;
    localparam logic [31:0] WG  = 32'h0070_0393;
    localparam logic [31:0] WH  = 32'h0080_0413;
    localparam logic [31:0] WI  = 32'h0090_0493;
    localparam logic [31:0] STALE = 32'hDEAD_BEEF;

    if_stage #(
        .XLEN     (32),
        .RESET_PC (32'h0000_0100)
    ) dut (
        .clk           (clk),
        .rst_n         (rst_n),
        .pc_sel        (pc_sel),
        .IFID_write    (IFID_write),
        .kill_IF       (kill_IF),
        .branch_target (branch_target),
        .jalr_target   (jalr_target),
        .trap_vec      (trap_vec),
        .imem_req      (imem_req),
        .imem_addr     (imem_addr),
        .imem_ack      (imem_ack),
        .imem_rdata    (imem_rdata),
        .ifid_pc       (ifid_pc),
        .ifid_instr    (ifid_instr),
        .ifid_valid    (ifid_valid)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_vec++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    // Advance across one rising edge; inputs were set before, outputs are checked after
    task automatic step();
        @(negedge clk);
    endtask

    // One cycle with an ack carrying word w, then ack removed
    task automatic ack_step(input logic [31:0] w);
        imem_ack   = 1'b1;
        imem_rdata = w;
        step();
        imem_ack   = 1'b0;
        imem_rdata = '0;
    endtask

    task automatic check_ifid(input string tag, input logic [31:0] p, input logic [31:0] i, input logic v);
        check({tag, ".pc"}, ifid_pc, p);
        check({tag, ".instr"}, ifid_instr, i);
        check({tag, ".valid"}, 32'(ifid_valid), 32'(v));
    endtask

    task automatic check_req(input string tag, input logic r, input logic [31:0] a);
        check({tag, ".req"}, 32'(imem_req), 32'(r));
        if (r) check({tag, ".addr"}, imem_addr, a);
    endtask

    initial begin
        rst_n = 1'b0; pc_sel = 3'b001; IFID_write = 1'b1; kill_IF = 1'b0;
        branch_target = '0; jalr_target = '0; trap_vec = 32'h0000_0040;
        imem_ack = 1'b0; imem_rdata = '0;
        step(); step();

        // Reset state
        check("rst.req", 32'(imem_req), 32'h0);
        check("rst.addr", imem_addr, 32'h100);
        check_ifid("rst", 32'h0, NOP, 1'b0);

        // 1: first request after reset release
        rst_n = 1'b1;
        step();
        check_req("t1", 1'b1, 32'h100);
        check_ifid("t1", 32'h0, NOP, 1'b0);

        // 2: sequential A, B, C, one idle cycle between acks
        ack_step(WA);
        check_ifid("t2a", 32'h100, WA, 1'b1);
        check_req("t2a", 1'b1, 32'h104);
        step();
        check_req("t2a_wait", 1'b1, 32'h104);
        ack_step(WB);
        check_ifid("t2b", 32'h104, WB, 1'b1);
        step();
        ack_step(WC);
        check_ifid("t2c", 32'h108, WC, 1'b1);
        check_req("t2c", 1'b1, 32'h10C);
        step();

        // 3: stall for 3 cycles while the 0x10C ack returns
        IFID_write = 1'b0;
        ack_step(WD);
        check_req("t3s1", 1'b0, 32'h0);
        check_ifid("t3s1", 32'h108, WC, 1'b1);
        step();
        step();
        check_req("t3s3", 1'b0, 32'h0);
        check_ifid("t3s3", 32'h108, WC, 1'b1);
        IFID_write = 1'b1;
        step();
        check_ifid("t3rel", 32'h10C, WD, 1'b1);
        check_req("t3rel", 1'b1, 32'h110);

        // 4: branch to 0x200 with 0x110 outstanding
        pc_sel = 3'b010; branch_target = 32'h200;
        step();
        pc_sel = 3'b001;
        check_req("t4drop", 1'b0, 32'h0);
        check_ifid("t4drop", 32'h10C, NOP, 1'b0);
        step();
        check_req("t4drop2", 1'b0, 32'h0);
        ack_step(STALE);
        check_req("t4new", 1'b1, 32'h200);
        check_ifid("t4new", 32'h10C, NOP, 1'b0);

        // 5: jalr to 0x300 coinciding with an ack, then killed fetch
        pc_sel = 3'b011; jalr_target = 32'h300;
        ack_step(WE);
        pc_sel = 3'b001;
        check_req("t5redir", 1'b1, 32'h300);
        check_ifid("t5redir", 32'h10C, NOP, 1'b0);
        step();
        kill_IF = 1'b1;
        ack_step(WF);
        kill_IF = 1'b0;
        check_ifid("t5kill", 32'h300, NOP, 1'b0);
        check_req("t5kill", 1'b1, 32'h304);

        // 6: branch to 0x200 on an ack, fetch 0x200, reset mid-request at 0x204
        pc_sel = 3'b010; branch_target = 32'h200;
        ack_step(STALE);
        pc_sel = 3'b001;
        check_req("t6br", 1'b1, 32'h200);
        step();
        ack_step(WG);
        check_ifid("t6g", 32'h200, WG, 1'b1);
        check_req("t6g", 1'b1, 32'h204);
        #2 rst_n = 1'b0;
        #1;
        check("t6async.req", 32'(imem_req), 32'h0);
        check("t6async.addr", imem_addr, 32'h100);
        check_ifid("t6async", 32'h0, NOP, 1'b0);
        step();
        rst_n = 1'b1;
        step();
        check_req("t6rel", 1'b1, 32'h100);

        // PC wrap at the top of the address space
        pc_sel = 3'b010; branch_target = 32'hFFFF_FFFC;
        ack_step(STALE);
        pc_sel = 3'b001;
        check_req("wrap0", 1'b1, 32'hFFFF_FFFC);
        step();
        ack_step(WH);
        check_ifid("wrap", 32'hFFFF_FFFC, WH, 1'b1);
        check_req("wrap", 1'b1, 32'h0);

        // pc_sel=000 loads IF/ID but keeps the PC
        step();
        pc_sel = 3'b000;
        ack_step(WI);
        pc_sel = 3'b001;
        check_ifid("hold", 32'h0, WI, 1'b1);
        check_req("hold", 1'b1, 32'h0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
